// File: rtl/ha_array_pkg.sv
// Shared constants, state encoding and saturation helper for the ha_array accumulator.
package ha_array_pkg;

  localparam int HA_ROWS  = 4;
  localparam int HA_T_W   = 9;
  localparam int HA_B_W   = 7;
  localparam int HA_P_W   = 16;
  localparam int HA_ACC_W = 17;
  localparam int HA_ROW_W = 10;
  localparam int HA_CNT_W = 2;
  localparam int HA_FIN_W = HA_ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } ha_acc_state_t;

  // Clamp anything that needs more than 16 bits to all-ones.
  function automatic logic [HA_P_W-1:0] sat16(input logic [HA_FIN_W-1:0] v);
    return (|v[HA_FIN_W-1:HA_P_W]) ? {HA_P_W{1'b1}} : v[HA_P_W-1:0];
  endfunction

endpackage

// File: rtl/ha_array_accumulator_if.sv
// Row-set input and product output handshakes of the ha_array accumulator.
interface ha_array_accumulator_if;
  import ha_array_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [HA_T_W-1:0] ha_array_0_t;
  logic [HA_T_W-1:0] ha_array_1_t;
  logic [HA_T_W-1:0] ha_array_2_t;
  logic [HA_T_W-1:0] ha_array_3_t;
  logic [HA_B_W-1:0] ha_array_0_b;
  logic [HA_B_W-1:0] ha_array_1_b;
  logic [HA_B_W-1:0] ha_array_2_b;
  logic [HA_B_W-1:0] ha_array_3_b;
  logic              out_valid;
  logic              out_ready;
  logic [HA_P_W-1:0] out_p;
  logic              busy;

  modport master (
    output in_valid, out_ready,
    output ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
    output ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
    input  in_ready, out_valid, out_p, busy
  );

  modport slave (
    input  in_valid, out_ready,
    input  ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
    input  ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
    output in_ready, out_valid, out_p, busy
  );

endinterface

// File: rtl/ha_row_value.sv
// Combinational value of one partial-product row: t + (b << 2), unsigned, 10 bits.
module ha_row_value
  import ha_array_pkg::*;
(
  input  logic [HA_T_W-1:0]   t_i,
  input  logic [HA_B_W-1:0]   b_i,
  output logic [HA_ROW_W-1:0] row_val_o
);

  assign row_val_o = HA_ROW_W'(t_i) + (HA_ROW_W'(b_i) << 2);

endmodule

// File: rtl/ha_array_accumulator.sv
// Captures four ha_array rows, adds one row per cycle into a 17-bit sum, presents sat16 result.
// Optional HA_ACC_BIAS_COMP_EN adds BIAS once in the last row cycle, before saturation.
module ha_array_accumulator
  import ha_array_pkg::*;
#(
  parameter logic [HA_P_W-1:0] BIAS = 16'd128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ha_array_accumulator_if.slave bus
);

  ha_acc_state_t                   state_q, state_d;
  logic [HA_CNT_W-1:0]             cnt_q, cnt_d;
  logic [HA_ACC_W-1:0]             acc_q, acc_d;
  logic [HA_ROWS-1:0][HA_T_W-1:0]  t_q, t_d;
  logic [HA_ROWS-1:0][HA_B_W-1:0]  b_q, b_d;
  logic [HA_P_W-1:0]               p_q, p_d;

  logic [HA_T_W-1:0]   row_t;
  logic [HA_B_W-1:0]   row_b;
  logic [HA_ROW_W-1:0] row_val;
  logic [HA_ACC_W-1:0] row_shifted;
  logic [HA_ACC_W-1:0] acc_sum;
  logic [HA_FIN_W-1:0] final_sum;

  assign row_t = t_q[cnt_q];
  assign row_b = b_q[cnt_q];

  ha_row_value u_row_value (
    .t_i       (row_t),
    .b_i       (row_b),
    .row_val_o (row_val)
  );

  // Four rows peak at 86615, so the 17-bit running sum never wraps.
  assign row_shifted = HA_ACC_W'(row_val) << {cnt_q, 1'b0};
  assign acc_sum     = acc_q + row_shifted;

`ifdef HA_ACC_BIAS_COMP_EN
  assign final_sum = {1'b0, acc_sum} + HA_FIN_W'(BIAS);
`else
  logic unused_bias;
  assign unused_bias = ^BIAS;
  assign final_sum   = {1'b0, acc_sum};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    t_d     = t_q;
    b_d     = b_q;
    p_d     = p_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          t_d[0]  = bus.ha_array_0_t;
          t_d[1]  = bus.ha_array_1_t;
          t_d[2]  = bus.ha_array_2_t;
          t_d[3]  = bus.ha_array_3_t;
          b_d[0]  = bus.ha_array_0_b;
          b_d[1]  = bus.ha_array_1_b;
          b_d[2]  = bus.ha_array_2_b;
          b_d[3]  = bus.ha_array_3_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          p_d     = sat16(final_sum);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      t_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      t_q     <= t_d;
      b_q     <= b_d;
      p_q     <= p_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_p     = p_q;

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Table-driven and hand-sequenced checks of ha_array_accumulator with an expected-product queue.
module tb_ha_array_accumulator;
  import ha_array_pkg::*;

`ifdef HA_ACC_BIAS_COMP_EN
  localparam int unsigned TB_BIAS = 128;
`else
  localparam int unsigned TB_BIAS = 0;
`endif

  typedef logic [3:0][8:0] rows_t_t;
  typedef logic [3:0][6:0] rows_b_t;

  typedef struct {
    string       name;
    rows_t_t     t;
    rows_b_t     b;
    int unsigned raw;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [15:0] sb[$];

  ha_array_accumulator_if bus_if ();

  ha_array_accumulator #(.BIAS(16'd128)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  function automatic logic [15:0] sat_tb(input int unsigned v);
    return (v > 32'd65535) ? 16'hFFFF : v[15:0];
  endfunction

  function automatic int unsigned raw_of(input rows_t_t t, input rows_b_t b);
    int unsigned s = 0;
    for (int r = 0; r < 4; r++) begin
      s += int'(t[r]) * (4 ** r);
      s += int'(b[r]) * (4 ** (r + 1));
    end
    return s;
  endfunction

  function automatic vec_t mk(input string n, input logic [8:0] t3, t2, t1, t0,
                              input logic [6:0] b3, b2, b1, b0, input int unsigned raw);
    vec_t v;
    v.name = n;
    v.t    = {t3, t2, t1, t0};
    v.b    = {b3, b2, b1, b0};
    v.raw  = raw;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_rows(input rows_t_t t, input rows_b_t b);
    bus_if.ha_array_0_t = t[0];
    bus_if.ha_array_1_t = t[1];
    bus_if.ha_array_2_t = t[2];
    bus_if.ha_array_3_t = t[3];
    bus_if.ha_array_0_b = b[0];
    bus_if.ha_array_1_b = b[1];
    bus_if.ha_array_2_b = b[2];
    bus_if.ha_array_3_b = b[3];
  endtask

  task automatic set_junk();
    rows_t_t jt;
    rows_b_t jb;
    for (int r = 0; r < 4; r++) begin
      jt[r] = 9'($urandom);
      jb[r] = 7'($urandom);
    end
    set_rows(jt, jb);
  endtask

  // Returns at the falling edge just after the accepting rising edge.
  task automatic send(input rows_t_t t, input rows_b_t b, input logic [15:0] exp);
    @(negedge clk);
    check("in_ready_idle", 32'(bus_if.in_ready), 32'd1);
    set_rows(t, b);
    bus_if.in_valid = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    set_junk();
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus_if.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic recv(input string name);
    logic [15:0] exp;
    check({name, "_busy"}, 32'(bus_if.busy), 32'd1);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got product with empty queue required queued entry", name);
    end else begin
      exp = sb.pop_front();
      check(name, 32'(bus_if.out_p), 32'(exp));
    end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    check({name, "_in_ready_back"}, 32'(bus_if.in_ready), 32'd1);
    check({name, "_out_valid_drop"}, 32'(bus_if.out_valid), 32'd0);
  endtask

  task automatic quiet_cycles(input string name, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus_if.out_valid) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    vec_t    vecs[10];
    int      lat;
    int      unstable;
    logic [15:0] held;
    rows_t_t rt;
    rows_b_t rb;

    vecs[0] = mk("zeros",      9'h000, 9'h000, 9'h000, 9'h000, 7'h00, 7'h00, 7'h00, 7'h00, 0);
    vecs[1] = mk("t0_one",     9'h000, 9'h000, 9'h000, 9'h001, 7'h00, 7'h00, 7'h00, 7'h00, 1);
    vecs[2] = mk("b1_one",     9'h000, 9'h000, 9'h000, 9'h000, 7'h00, 7'h00, 7'h01, 7'h00, 16);
    vecs[3] = mk("row3_only",  9'h1FF, 9'h000, 9'h000, 9'h000, 7'h7F, 7'h00, 7'h00, 7'h00, 65216);
    vecs[4] = mk("sat_r3_t2",  9'h1FF, 9'h1FF, 9'h000, 9'h000, 7'h7F, 7'h00, 7'h00, 7'h00, 73392);
    vecs[5] = mk("all_ones",   9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 86615);
    vecs[6] = mk("row0_mix",   9'h000, 9'h000, 9'h000, 9'h155, 7'h00, 7'h00, 7'h00, 7'h2A, 509);
    vecs[7] = mk("t1_b2",      9'h000, 9'h000, 9'h0A3, 9'h000, 7'h00, 7'h11, 7'h00, 7'h00, 1740);
    vecs[8] = mk("t2_b0",      9'h000, 9'h100, 9'h000, 9'h000, 7'h00, 7'h00, 7'h00, 7'h40, 4352);
    vecs[9] = mk("b3_top",     9'h000, 9'h000, 9'h000, 9'h000, 7'h40, 7'h00, 7'h00, 7'h00, 16384);

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    set_rows('0, '0);

    #2;
    check("rst_out_p", 32'(bus_if.out_p), 32'd0);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].t, vecs[i].b, sat_tb(vecs[i].raw + TB_BIAS));
      wait_out(lat);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'd4);
      recv(vecs[i].name);
    end

    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < 4; r++) begin
        rt[r] = 9'($urandom);
        rb[r] = 7'($urandom);
      end
      send(rt, rb, sat_tb(raw_of(rt, rb) + TB_BIAS));
      wait_out(lat);
      check("rand_latency", 32'(lat), 32'd4);
      recv("rand");
    end

    // Backpressure: product must hold while in_valid with fresh data is ignored.
    rt = '0;
    rb = '0;
    rt[0] = 9'd5;
    send(rt, rb, sat_tb(5 + TB_BIAS));
    bus_if.in_valid = 1'b1;
    wait_out(lat);
    check("bp_latency", 32'(lat), 32'd4);
    held = bus_if.out_p;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_junk();
      if (bus_if.out_p !== held || bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b0)
        unstable++;
    end
    check("bp_hold_stable", 32'(unstable), 32'd0);
    bus_if.in_valid = 1'b0;
    recv("bp_product");
    quiet_cycles("bp_no_capture", 8);

    // Reset during the second accumulation cycle drops the transaction.
    rt = '0;
    rt[1] = 9'h0FF;
    send(rt, rb, sat_tb(raw_of(rt, rb) + TB_BIAS));
    @(negedge clk);
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    check("midacc_rst_out_p", 32'(bus_if.out_p), 32'd0);
    check("midacc_rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("midacc_rst_busy", 32'(bus_if.busy), 32'd0);
    check("midacc_rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_cycles("midacc_no_output", 8);
    send('0, '0, sat_tb(TB_BIAS));
    wait_out(lat);
    check("post_rst_latency", 32'(lat), 32'd4);
    recv("post_rst_zeros");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ha_array_accumulator.md
# ha_array_accumulator

Sequential back end for the 8x8 unsigned half-adder-array partial-product generators. It accepts one set of four `ha_array` rows (each a `t` sum vector and a `b` carry vector) over a valid/ready handshake and accumulates one row per cycle into a 16-bit product. It then presents the product on a valid/ready output. It sits directly downstream of any `unsigned_mul_8x8_*` ha_array front end and is shared by all approximation variants.

## Interface
- `BIAS`, default 16'd128: constant added to the final product when `HA_ACC_BIAS_COMP_EN` is defined; ignored otherwise.
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  row set present
- `in_ready`  out  1  block can capture a row set
- `ha_array_r_t` (r = 0..3)  in  9  row r sum vector; bit i has weight 2^(i+2r)
- `ha_array_r_b` (r = 0..3)  in  7  row r carry vector; bit i has weight 2^(i+2+2r)
- `out_valid`  out  1  product valid
- `out_ready`  in  1  consumer accepts product
- `out_p`  out  16  accumulated, saturated product
- `busy`  out  1  high in ACC or DONE

## Operation
- FSM states: IDLE, ACC, DONE.
- **IDLE:** `in_ready`=1. When `in_valid` and `in_ready` are both high, the block:
  - captures all 8 input vectors into registers;
  - clears the 17-bit accumulator and the 2-bit row counter;
  - moves to ACC.
- **ACC:** `in_ready`=0.
  - Each cycle, acc += row_val(cnt) << (2*cnt), where row_val = t + (b << 2) is 10 bits wide (zero-extended, unsigned).
  - cnt increments by 1 each cycle.
  - After the cnt=3 addition, the block moves to DONE and loads `out_p` = sat16(final acc [+ BIAS]).
- **DONE:** `out_valid`=1 and `out_p` is held stable.
  - On `out_ready`, the block returns to IDLE and `out_valid` falls.
  - If `out_ready` stays low, the state and `out_p` hold indefinitely.
- Arithmetic:
  - The accumulator is 17 bits unsigned.
  - sat16: any result above 16'hFFFF is clamped to 16'hFFFF.
  - No wrap-around is permitted.
- Boundary conditions:
  - `in_valid` outside IDLE is ignored and no input is captured.
  - Input changes during ACC have no effect, because captured copies are used.
  - `out_ready` outside DONE is ignored.
  - `rst_n` low at any time, including mid-ACC or in DONE, immediately forces IDLE and discards any partial sum; no output is produced for that transaction.

## Timing
- Reset values:
  - state=IDLE, cnt=0, acc=0
  - `out_p`=16'h0000, `out_valid`=0, `busy`=0
  - `in_ready`=1 (combinational from state, so it is high during reset)
- Latency: the input handshake at edge k makes `out_valid` high after edge k+4.
  - Edges k+1 through k+4 perform the four row additions.
  - The last addition, the bias and saturation all register at edge k+4.
- Throughput: one product per 6 cycles with `out_ready` tied high (1 accept + 4 ACC + 1 DONE).
- `in_ready`, `out_valid` and `busy` are pure decodes of the state register.
- No combinational path exists from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Configuration
- `HA_ACC_BIAS_COMP_EN` defined: `BIAS` is added once, in the cnt=3 cycle, before saturation. This is error-mean compensation for approximate front ends.
- Undefined: no bias adder is present, and `out_p` = sat16(sum of rows).
- Latency and handshake behaviour are identical in both builds.

## Structure
- Shared package `ha_array_pkg`:
  - constants HA_ROWS=4, HA_T_W=9, HA_B_W=7, HA_P_W=16, HA_ACC_W=17;
  - state enum `ha_acc_state_t` (IDLE, ACC, DONE).
- Sub-module `ha_row_value`: combinational; takes t[8:0] and b[6:0] and produces row_val[9:0] = t + (b << 2). It is instantiated once and fed by a row mux indexed by cnt.

## Test plan
- All inputs zero, macro off:
  - `out_valid` rises 4 cycles after the accept;
  - `out_p`=16'h0000;
  - `in_ready` returns to 1 one cycle after `out_ready`.
- Only `ha_array_0_t`=9'h001 -> `out_p`=16'd1.
- Only `ha_array_1_b`=7'h01 -> `out_p`=16'd16.
- Saturation: `ha_array_3_t`=9'h1FF, `ha_array_3_b`=7'h7F (alone these give 65216), plus `ha_array_2_t`=9'h1FF -> `out_p`=16'hFFFF.
- Backpressure and reset:
  - hold `out_ready`=0 for 10 cycles -> `out_p` stable and `in_valid` ignored;
  - assert `rst_n` low in the 2nd ACC cycle -> all outputs at reset values;
  - the next transaction of zeros -> `out_p`=0.
- Build with `HA_ACC_BIAS_COMP_EN` and `BIAS`=128: zero inputs -> `out_p`=16'd128; the saturation case above -> 16'hFFFF.
